// File: rtl/bcd_scan_controller_pkg.sv
// Shared definitions for the two-digit BCD scan controller: scan states,
// digit-enable and blank constants, and the active-low segment table.
package bcd_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_UNITS   = 2'd0,
        ST_BLANK_U = 2'd1,
        ST_TENS    = 2'd2,
        ST_BLANK_T = 2'd3
    } scan_state_t;

    localparam logic [1:0] DIGIT_UNITS = 2'b10;
    localparam logic [1:0] DIGIT_TENS  = 2'b01;
    localparam logic [1:0] DIGIT_OFF   = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_enc(input logic [3:0] digit);
        logic [6:0] w_seg;
        w_seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            w_seg = SEG_TABLE[digit];
        end
        return w_seg;
    endfunction

endpackage

// File: rtl/bcd_scan_controller_if.sv
// Switch/display side bundle of the BCD scan controller. The board side
// drives the controls (master); the controller drives the display (slave).
interface bcd_scan_controller_if;

    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count;
    logic [7:0] bcd;
    logic       wrap;
    logic [6:0] seg_n;
    logic [1:0] digit_n;

    modport master (
        output enable, up_down, load, load_value,
        input  count, bcd, wrap, seg_n, digit_n
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output count, bcd, wrap, seg_n, digit_n
    );

endinterface

// File: rtl/bcd_scan_controller_bin4_to_bcd.sv
// Combinational 4-bit binary to two-digit BCD converter; tens is 0 or 1.
module bin4_to_bcd (
    input  logic [3:0] i_bin,
    output logic [7:0] o_bcd
);

    logic       w_tens;
    logic [3:0] w_units;

    assign w_tens  = (i_bin >= 4'd10);
    assign w_units = i_bin - (w_tens ? 4'd10 : 4'd0);
    assign o_bcd   = {3'b000, w_tens, w_units};

endmodule

// File: rtl/bcd_scan_controller.sv
// Tick prescaler, 4-bit up/down counter with load, registered BCD value and
// a four-state scan that multiplexes tens/units onto one segment bus.
module bcd_scan_controller
    import bcd_scan_controller_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bcd_scan_controller_if.slave  bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_count;
    logic          r_wrap;
    logic [7:0]    r_bcd;
    logic [SW-1:0] r_scan;
    scan_state_t   r_state;
    logic [6:0]    r_seg_n;
    logic [1:0]    r_digit_n;

    logic          w_tick;
    logic [7:0]    w_bcd;

    assign w_tick = bus.enable && (r_presc == TICK_MAX);

    bin4_to_bcd u_bin4_to_bcd (
        .i_bin (r_count),
        .o_bcd (w_bcd)
    );

    // NOTE: every state register uses <= so all flops sample the values from
    // before the edge; a blocking = here would chain updates within one edge.
    // NOTE: reset is asynchronous, so the sensitivity list carries negedge
    // reset_n and outputs blank without waiting for a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_count <= 4'd0;
            r_wrap  <= 1'b0;
            r_bcd   <= 8'h00;
        end else begin
            r_bcd <= w_bcd;
            if (bus.load) begin
                // Load restarts the tick phase and swallows a coincident tick.
                r_count <= bus.load_value;
                r_presc <= '0;
                r_wrap  <= 1'b0;
            end else begin
                if (bus.enable) begin
                    r_presc <= (r_presc == TICK_MAX) ? '0 : r_presc + 1'b1;
                end
                if (w_tick) begin
                    if (bus.up_down) begin
                        r_count <= r_count + 4'd1;
                        r_wrap  <= (r_count == 4'd15);
                    end else begin
                        r_count <= r_count - 4'd1;
                        r_wrap  <= (r_count == 4'd0);
                    end
                end else begin
                    r_wrap <= 1'b0;
                end
            end
        end
    end

    // Outputs are registered from the current state, so the display lags the
    // state by one cycle while keeping seg_n and digit_n edge-aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_BLANK_T;
            r_scan    <= '0;
            r_seg_n   <= SEG_BLANK;
            r_digit_n <= DIGIT_OFF;
        end else begin
            unique case (r_state)
                ST_UNITS: begin
                    r_digit_n <= DIGIT_UNITS;
                    r_seg_n   <= seg_enc(r_bcd[3:0]);
                    if (r_scan == SCAN_MAX) begin
                        r_scan  <= '0;
                        r_state <= ST_BLANK_U;
                    end else begin
                        r_scan <= r_scan + 1'b1;
                    end
                end
                ST_BLANK_U: begin
                    r_digit_n <= DIGIT_OFF;
                    r_seg_n   <= SEG_BLANK;
                    r_state   <= ST_TENS;
                end
                ST_TENS: begin
                    r_digit_n <= DIGIT_TENS;
                    r_seg_n   <= (r_bcd[7:4] == 4'd0) ? SEG_BLANK
                                                      : seg_enc(r_bcd[7:4]);
                    if (r_scan == SCAN_MAX) begin
                        r_scan  <= '0;
                        r_state <= ST_BLANK_T;
                    end else begin
                        r_scan <= r_scan + 1'b1;
                    end
                end
                ST_BLANK_T: begin
                    r_digit_n <= DIGIT_OFF;
                    r_seg_n   <= SEG_BLANK;
                    r_state   <= ST_UNITS;
                end
                default: begin
                    r_digit_n <= DIGIT_OFF;
                    r_seg_n   <= SEG_BLANK;
                    r_state   <= ST_BLANK_T;
                end
            endcase
        end
    end

    assign bus.count   = r_count;
    assign bus.wrap    = r_wrap;
    assign bus.bcd     = r_bcd;
    assign bus.seg_n   = r_seg_n;
    assign bus.digit_n = r_digit_n;

endmodule

// File: doc/bcd_scan_controller.md
# bcd_scan_controller

Sequencing controller for the 4-bit binary-to-BCD converter on the clock-to-seven-segment path. It divides the system clock into a count tick and advances a 4-bit up/down counter with load. It registers the counter's two-digit BCD value and time-multiplexes the tens and units digits onto one shared active-low seven-segment bus, with blanking between digits. It sits between the board clock and switches and the two-digit display.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clock cycles per count tick; legal range ≥2.
- SCAN_DIV, 50_000: clock cycles each digit is shown; legal range ≥2.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  when 1, the prescaler runs and ticks advance the count.
- up_down  in  1  1 = count up, 0 = count down; sampled on each tick.
- load  in  1  synchronous load strobe.
- load_value  in  4  value written to count on load.
- count  out  4  current binary count (0–15).
- bcd  out  8  registered conversion of count: [7:4] tens (0 or 1), [3:0] units (0–9).
- wrap  out  1  one-cycle pulse when count wraps (15→0 up, or 0→15 down).
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- digit_n  out  2  active-low digit enables: [0] units, [1] tens.

## Operation
- Prescaler: counts 0..TICK_DIV-1 while enable=1 and holds while enable=0. A tick is asserted in the cycle the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
- Counter priority, highest first:
  - load: count←load_value and prescaler←0. A tick in the same cycle is discarded and wrap stays 0.
  - tick: count±1 modulo 16. wrap=1 for that cycle when the step crosses 15↔0.
- Conversion: tens = (count ≥ 10); units = count − 10·tens. The result is registered into bcd.
- Scan FSM states: UNITS, BLANK_U, TENS, BLANK_T.
  - UNITS → BLANK_U after SCAN_DIV cycles.
  - BLANK_U → TENS after 1 cycle.
  - TENS → BLANK_T after SCAN_DIV cycles.
  - BLANK_T → UNITS after 1 cycle.
  - The scan runs regardless of enable.
- Outputs by state:
  - UNITS: digit_n=2'b10, seg_n=enc(units).
  - TENS: digit_n=2'b01, seg_n=enc(tens). When tens=0, seg_n=7'h7F (leading-zero blank).
  - BLANK states: digit_n=2'b11, seg_n=7'h7F.
- Segment encoder enc(): standard active-low 0–9, e.g. 0=7'h40, 1=7'h79, 5=7'h12, 9=7'h10. Inputs 10–15 are unreachable and map to 7'h7F.
- seg_n and digit_n are registered from the FSM state and bcd, and always change on the same edge.

## Timing
- Reset values: count=0, bcd=8'h00, wrap=0, seg_n=7'h7F, digit_n=2'b11, prescaler=0, scan counter=0, FSM state=BLANK_T.
- First lit cycle after reset release: UNITS is entered on the 1st edge, and the UNITS outputs appear on the 2nd edge.
- Tick to count: the count updates on the edge that ends the tick cycle. wrap is asserted for the cycle after that edge, aligned with the new count.
- count to bcd: 1 cycle of latency.
- bcd to seg_n: up to 1 further cycle, and only while the corresponding digit is shown.
- Reset asserted mid-operation: all registers go to their reset values immediately, with no clock needed.
- enable deasserted: the prescaler freezes and keeps its value; counting resumes from that phase when enable returns.
- load held high for multiple cycles: count is pinned to load_value and no ticks occur.

## Structure
- Shared package/header holds:
  - FSM state encodings (2-bit).
  - The digit enable constants 2'b10, 2'b01 and 2'b11.
  - The blank constant 7'h7F.
  - The 10-entry segment table.
- One sub-module, bin4_to_bcd: a combinational 4-bit→8-bit converter instantiated once. All registers stay in the controller.

## Test plan
Benches use TICK_DIV=4 and SCAN_DIV=3.
- Reset release, enable=1, up: count 0→1→2 at one tick per 4 cycles; bcd=8'h02 one cycle after count=2; seg_n/digit_n=7'h7F/2'b11 until the first UNITS.
- Count up to 9 then 10: bcd goes 8'h09 → 8'h10. In TENS, seg_n=7'h79 with digit_n=2'b01; in UNITS, seg_n=7'h40.
- Up from 15: count→0 with wrap=1 for exactly one cycle. Down from 0: count→15 with a wrap pulse, then bcd=8'h15.
- load=1, load_value=12 in the same cycle as a tick: count=12, no increment, no wrap; the next tick arrives 4 cycles later.
- Scan sequence: the exact cycle order UNITS×3, BLANK×1, TENS×3, BLANK×1. With count<10, TENS shows seg_n=7'h7F and digit_n=2'b01.
- reset_n pulsed low mid-TENS between clock edges: outputs read 7'h7F/2'b11, count=0 and wrap=0 immediately. Recovery follows the reset-release sequence.
